// File: rtl/alu_wb_stage.sv
// alu_wb_stage: ALU writeback FIFO toward the register file, with an in-order APSR flag register (optional APSR_STICKY_Q_EN makes Q sticky with clr_q).
module alu_wb_stage #(
  parameter int DEPTH = 4,
  parameter int AW = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              alu_out,
  input  logic [31:0]              apsr_in,
  input  logic [AW-1:0]            rd_addr,
  input  logic                     wr_req,
  input  logic                     set_flags,
`ifdef APSR_STICKY_Q_EN
  input  logic                     clr_q,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [AW-1:0]            out_addr,
  output logic [31:0]              apsr_q,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  logic [AW+31:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count_n;
  logic [4:0] flags;
  logic accept, push, pop, upd, q_n, unused_bits;
  assign in_ready = count != (PW+1)'(DEPTH);
  assign out_valid = count != '0;
  assign accept = in_valid & in_ready;
  assign push = accept & wr_req;
  assign pop = out_valid & out_ready;
  assign upd = accept & set_flags;
  assign count_n = count + (PW+1)'(push) - (PW+1)'(pop);
  assign apsr_q = {flags, 27'd0};
  assign unused_bits = ^apsr_in[26:0];
`ifdef APSR_STICKY_Q_EN
  assign q_n = (clr_q ? 1'b0 : flags[0]) | (upd & apsr_in[27]);
`else
  assign q_n = upd ? apsr_in[27] : flags[0];
`endif
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {alu_out, rd_addr};
  // Head register is loaded with whatever will sit at the head after this edge;
  // when the FIFO drains to one fresh entry that entry is the incoming beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      out_data <= '0;
      out_addr <= '0;
      flags <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count_n;
      flags <= {upd ? apsr_in[31:28] : flags[4:1], q_n};
      if (count_n != '0)
        {out_data, out_addr} <= (count == (PW+1)'(pop)) ? {alu_out, rd_addr} : mem[rd_ptr + PW'(pop)];
    end
  end
endmodule

// File: tb/tb_alu_wb_stage.sv
// tb_alu_wb_stage: scoreboard bench for alu_wb_stage; pops are checked in acceptance order.
module tb_alu_wb_stage;
  localparam int AW = 5;
  logic clk = 0, rst = 0, in_valid = 0, in_ready, wr_req = 0, set_flags = 0;
  logic out_valid, out_ready = 0;
  logic [31:0] alu_out = 0, apsr_in = 0, out_data, apsr_q;
  logic [AW-1:0] rd_addr = 0, out_addr;
  logic [2:0] count;
`ifdef APSR_STICKY_Q_EN
  logic clr_q = 0;
`endif
  int n_cmp = 0, n_err = 0;
  logic [AW+31:0] sb [$];

  always #5 clk = ~clk;

  alu_wb_stage #(.DEPTH(4), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .apsr_in(apsr_in), .rd_addr(rd_addr),
    .wr_req(wr_req), .set_flags(set_flags),
`ifdef APSR_STICKY_Q_EN
    .clr_q(clr_q),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .apsr_q(apsr_q), .count(count));

  // Inputs are stable at the falling edge, so a pop seen here happens on the next rising edge.
  always @(negedge clk) begin
    logic [AW+31:0] exp;
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL pop_unexpected: got data=%h addr=%0d, required no output", out_data, out_addr);
      end else begin
        exp = sb.pop_front();
        if ({out_data, out_addr} !== exp) begin
          n_err++;
          $display("FAIL pop_order: got data=%h addr=%0d, required data=%h addr=%0d",
                   out_data, out_addr, exp[AW+31:AW], exp[AW-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic [AW-1:0] a, input logic wr, input logic sf, input logic [31:0] ap);
    in_valid = 1; alu_out = d; rd_addr = a; wr_req = wr; set_flags = sf; apsr_in = ap;
    if (in_ready && wr) sb.push_back({d, a});
    tick();
    in_valid = 0; wr_req = 0; set_flags = 0;
  endtask

  task automatic test_reset();
    rst = 1; tick(); rst = 0;
    n_cmp++;
    if ({count, out_valid, out_data, out_addr, apsr_q, in_ready} !== {3'd0, 1'b0, 32'd0, 5'd0, 32'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset: got count=%0d ov=%b d=%h a=%0d apsr=%h rdy=%b, required 0 0 0 0 0 1",
               count, out_valid, out_data, out_addr, apsr_q, in_ready);
    end
  endtask

  task automatic test_single();
    out_ready = 1;
    beat(32'h0000000C, 5'd3, 1, 1, 32'h0);
    n_cmp++;
    if ({out_valid, out_data, out_addr, count} !== {1'b1, 32'h0C, 5'd3, 3'd1}) begin
      n_err++;
      $display("FAIL single_out: got ov=%b d=%h a=%0d cnt=%0d, required 1 0000000c 3 1", out_valid, out_data, out_addr, count);
    end
    tick();
    n_cmp++;
    if ({count, out_valid, apsr_q} !== {3'd0, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL single_drain: got cnt=%0d ov=%b apsr=%h, required 0 0 0", count, out_valid, apsr_q);
    end
  endtask

  task automatic test_flag_only();
    beat(32'h0, 5'd0, 0, 1, 32'h40000000);
    n_cmp++;
    if ({apsr_q, out_valid, count} !== {32'h40000000, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL flag_only: got apsr=%h ov=%b cnt=%0d, required 40000000 0 0", apsr_q, out_valid, count);
    end
    beat(32'h5, 5'd7, 0, 0, 32'hF0000000);
    n_cmp++;
    if ({apsr_q, count} !== {32'h40000000, 3'd0}) begin
      n_err++;
      $display("FAIL dropped: got apsr=%h cnt=%0d, required 40000000 0", apsr_q, count);
    end
  endtask

  task automatic test_fill_wrap();
    logic [31:0] d [4] = '{32'hFFFFFFFE, 32'h1, 32'h2, 32'h3};
    out_ready = 0;
    for (int i = 0; i < 4; i++) beat(d[i], 5'(i + 8), 1, 0, 32'h0);
    n_cmp++;
    if ({count, in_ready, out_data} !== {3'd4, 1'b0, 32'hFFFFFFFE}) begin
      n_err++;
      $display("FAIL full: got cnt=%0d rdy=%b head=%h, required 4 0 fffffffe", count, in_ready, out_data);
    end
    beat(32'hDEAD, 5'd31, 1, 1, 32'hF8000000);
    n_cmp++;
    if ({count, apsr_q} !== {3'd4, 32'h40000000}) begin
      n_err++;
      $display("FAIL full_ignore: got cnt=%0d apsr=%h, required 4 40000000", count, apsr_q);
    end
    out_ready = 1;
    tick();
    n_cmp++;
    if ({count, in_ready} !== {3'd3, 1'b1}) begin
      n_err++;
      $display("FAIL ready_after_pop: got cnt=%0d rdy=%b, required 3 1", count, in_ready);
    end
    repeat (3) tick();
    for (int i = 0; i < 3; i++) beat(32'h100 + i, 5'(i + 20), 1, 0, 32'h0);
    repeat (3) tick();
    n_cmp++;
    if ({count, out_valid} !== {3'd0, 1'b0} || sb.size() != 0) begin
      n_err++;
      $display("FAIL wrap_drain: got cnt=%0d ov=%b pending=%0d, required 0 0 0", count, out_valid, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 0;
    beat(32'hA, 5'd1, 1, 0, 32'h0);
    beat(32'hB, 5'd2, 1, 0, 32'h0);
    tick();
    n_cmp++;
    if ({count, out_data, out_addr} !== {3'd2, 32'hA, 5'd1}) begin
      n_err++;
      $display("FAIL hold: got cnt=%0d d=%h a=%0d, required 2 0000000a 1", count, out_data, out_addr);
    end
    out_ready = 1;
    beat(32'hC, 5'd3, 1, 0, 32'h0);
    out_ready = 0;
    n_cmp++;
    if ({count, out_data, out_addr} !== {3'd2, 32'hB, 5'd2}) begin
      n_err++;
      $display("FAIL push_pop: got cnt=%0d d=%h a=%0d, required 2 0000000b 2", count, out_data, out_addr);
    end
    out_ready = 1;
    repeat (2) tick();
    out_ready = 0;
    n_cmp++;
    if ({count, out_data} !== {3'd0, 32'hC} || sb.size() != 0) begin
      n_err++;
      $display("FAIL push_pop_drain: got cnt=%0d last=%h pending=%0d, required 0 0000000c 0", count, out_data, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    beat(32'h11, 5'd0, 1, 0, 32'h0);
    beat(32'h22, 5'd4, 1, 0, 32'h0);
    beat(32'h33, 5'd5, 1, 1, 32'hF0000000);
    n_cmp++;
    if ({count, apsr_q} !== {3'd3, 32'hF0000000}) begin
      n_err++;
      $display("FAIL mid_setup: got cnt=%0d apsr=%h, required 3 f0000000", count, apsr_q);
    end
    rst = 1; tick(); rst = 0;
    sb.delete();
    n_cmp++;
    if ({count, out_valid, apsr_q, in_ready, out_data, out_addr} !== {3'd0, 1'b0, 32'h0, 1'b1, 32'h0, 5'd0}) begin
      n_err++;
      $display("FAIL mid_reset: got cnt=%0d ov=%b apsr=%h rdy=%b d=%h a=%0d, required 0 0 0 1 0 0",
               count, out_valid, apsr_q, in_ready, out_data, out_addr);
    end
  endtask

  task automatic test_sticky_q();
    beat(32'h0, 5'd0, 0, 1, 32'h08000000);
    beat(32'h0, 5'd0, 0, 1, 32'h80000000);
    n_cmp++;
`ifdef APSR_STICKY_Q_EN
    if (apsr_q !== 32'h88000000) begin
      n_err++;
      $display("FAIL sticky_q: got apsr=%h, required 88000000", apsr_q);
    end
    clr_q = 1; tick(); clr_q = 0;
    n_cmp++;
    if (apsr_q !== 32'h80000000) begin
      n_err++;
      $display("FAIL clr_q: got apsr=%h, required 80000000", apsr_q);
    end
    clr_q = 1;
    beat(32'h0, 5'd0, 0, 1, 32'h08000000);
    clr_q = 0;
    n_cmp++;
    if (apsr_q !== 32'h08000000) begin
      n_err++;
      $display("FAIL clr_vs_set: got apsr=%h, required 08000000", apsr_q);
    end
`else
    if (apsr_q !== 32'h80000000) begin
      n_err++;
      $display("FAIL q_overwrite: got apsr=%h, required 80000000", apsr_q);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_flag_only();
    test_fill_wrap();
    test_back_to_back();
    test_reset_mid();
    test_sticky_q();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
